// File: rtl/cnfg_pkg.sv
// Shared types and helpers for the serial configuration register block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnfg_pkg;

    // Controller states: IDLE means no bits shifted since the last commit or reset.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // The bit counter must reach SIZE+1, which marks an over-long frame.
    function automatic int cnt_width(input int size);
        return $clog2(size + 2);
    endfunction

endpackage

// File: rtl/cnfg_sreg_ctrl_if.sv
// Bus bundle between a configuration master and cnfg_sreg_ctrl.
// Latency: n/a (wires only); so/out are combinational in the slave.
// Backpressure: none; shift_en/ld are qualifiers, not handshakes.
// Ports: def_conf, def_val, si, shift_en, ld (and rb with CNFG_READBACK_EN) toward the slave;
//        so, out_sr, out, loaded, load_err, bit_cnt back to the master.
interface cnfg_sreg_ctrl_if #(
    parameter int SIZE = 16
);
    localparam int CNT_W = cnfg_pkg::cnt_width(SIZE);

    logic             def_conf;
    logic [SIZE-1:0]  def_val;
    logic             si;
    logic             shift_en;
    logic             ld;
`ifdef CNFG_READBACK_EN
    logic             rb;
`endif
    logic             so;
    logic [SIZE-1:0]  out_sr;
    logic [SIZE-1:0]  out;
    logic             loaded;
    logic             load_err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output def_conf, def_val, si, shift_en, ld,
`ifdef CNFG_READBACK_EN
        output rb,
`endif
        input  so, out_sr, out, loaded, load_err, bit_cnt
    );

    modport slave (
        input  def_conf, def_val, si, shift_en, ld,
`ifdef CNFG_READBACK_EN
        input  rb,
`endif
        output so, out_sr, out, loaded, load_err, bit_cnt
    );

endinterface

// File: rtl/cnfg_bit_counter.sv
// Saturating bit counter for the configuration shift chain.
// Latency: count updates on the rising clk edge after inc/clr; clr has priority over inc.
// Backpressure: none; increments are dropped once the count sits at SIZE+1.
// Ports: clk, rst (async active-high), clr, inc, cnt.
module cnfg_bit_counter #(
    parameter int SIZE  = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // SIZE+1 means "more bits than the chain holds"; it never wraps back to a valid length.
    localparam logic [CNT_W-1:0] SAT = CNT_W'(SIZE + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnfg_sreg_ctrl.sv
// Serial configuration chain with length-checked commit into an applied latch.
// Latency: ld sampled at edge n -> latch/out/loaded update at edge n+1; so and out are combinational.
// Backpressure: none; shift_en and ld are ignored during the single LOAD cycle.
// Ports: clk, rst (async active-high), bus (cnfg_sreg_ctrl_if.slave).
// Optional feature: define CNFG_READBACK_EN to add bus.rb, which copies the latch into the chain in IDLE.
module cnfg_sreg_ctrl
    import cnfg_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cnfg_sreg_ctrl_if.slave      bus
);

    localparam int CNT_W = cnt_width(SIZE);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);

    generate
        if (SIZE < 2) begin : g_size_check
            $error("cnfg_sreg_ctrl: SIZE must be at least 2");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [SIZE-1:0]  sr_q, sr_d;
    logic [SIZE-1:0]  latch_q, latch_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;
    logic             cnt_inc, cnt_clr;
    logic [CNT_W-1:0] bit_cnt;

    cnfg_bit_counter #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (bit_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr_q     <= '0;
            latch_q  <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr_q     <= sr_d;
            latch_q  <= latch_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_d      = sr_q;
        latch_d   = latch_q;
        loaded_d  = 1'b0;
        err_d     = err_q;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;

        case (state)
            IDLE, SHIFT: begin
`ifdef CNFG_READBACK_EN
                // Readback only from IDLE, and a simultaneous ld takes the commit path instead.
                if ((state == IDLE) && bus.rb && !bus.ld) begin
                    sr_d = latch_q;
                end else
`endif
                if (bus.shift_en) begin
                    sr_d    = {sr_q[SIZE-2:0], bus.si};
                    cnt_inc = 1'b1;
                    state_nxt = SHIFT;
                end
                // A bit shifted alongside ld still counts toward the frame being committed.
                if (bus.ld) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                // Only an exact-length frame is applied; short, empty or over-long frames flag an error.
                if (bit_cnt == FULL) begin
                    latch_d  = sr_q;
                    loaded_d = 1'b1;
                    err_d    = 1'b0;
                end else begin
                    err_d    = 1'b1;
                end
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    assign bus.so       = sr_q[SIZE-1];
    assign bus.out_sr   = sr_q;
    assign bus.out      = bus.def_conf ? bus.def_val : latch_q;
    assign bus.loaded   = loaded_q;
    assign bus.load_err = err_q;
    assign bus.bit_cnt  = bit_cnt;

endmodule

// File: tb/tb_cnfg_sreg_ctrl.sv
// Directed self-checking bench for cnfg_sreg_ctrl with SIZE=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Define CNFG_READBACK_EN to include the readback sequence.
module tb_cnfg_sreg_ctrl;

    localparam int SIZE = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    cnfg_sreg_ctrl_if #(.SIZE(SIZE)) bus ();

    cnfg_sreg_ctrl #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bus.si       = b;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
    endtask

    // MSB-first: the first bit shifted ends up in the highest position.
    task automatic shift_word(input logic [11:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            shift_bit(val[i]);
        end
    endtask

    // Leaves the bench right after the edge where the LOAD state resolves.
    task automatic commit();
        bus.ld = 1'b1;
        tick();
        bus.ld = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.def_conf = 1'b0;
        bus.def_val  = '0;
        bus.si       = 1'b0;
        bus.shift_en = 1'b0;
        bus.ld       = 1'b0;
`ifdef CNFG_READBACK_EN
        bus.rb       = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_out_sr",   bus.out_sr,   8'h00);
        check("rst_out",      bus.out,      8'h00);
        check("rst_bit_cnt",  bus.bit_cnt,  0);
        check("rst_loaded",   bus.loaded,   0);
        check("rst_load_err", bus.load_err, 0);
        bus.def_conf = 1'b1;
        bus.def_val  = 8'h5A;
        #1;
        check("rst_out_def",  bus.out,      8'h5A);
        bus.def_conf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Good 8-bit frame A5
        shift_word(12'h0A5, 8);
        check("a5_bit_cnt", bus.bit_cnt, 8);
        check("a5_out_sr",  bus.out_sr,  8'hA5);
        check("a5_so",      bus.so,      1);
        bus.ld = 1'b1;
        tick();
        bus.ld = 1'b0;
        check("a5_loaded_early", bus.loaded, 0);
        check("a5_out_early",    bus.out,    8'h00);
        tick();
        check("a5_loaded",   bus.loaded,   1);
        check("a5_out",      bus.out,      8'hA5);
        check("a5_load_err", bus.load_err, 0);
        check("a5_cnt_clr",  bus.bit_cnt,  0);
        tick();
        check("a5_loaded_pulse", bus.loaded, 0);

        // Short frame then a correct one
        shift_word(12'h055, 7);
        check("short_bit_cnt", bus.bit_cnt, 7);
        commit();
        check("short_load_err", bus.load_err, 1);
        check("short_loaded",   bus.loaded,   0);
        check("short_out",      bus.out,      8'hA5);
        check("short_bit_cnt0", bus.bit_cnt,  0);
        shift_word(12'h069, 8);
        commit();
        check("fix_load_err", bus.load_err, 0);
        check("fix_loaded",   bus.loaded,   1);
        check("fix_out",      bus.out,      8'h69);

        // Over-long frame saturates the counter
        shift_word(12'hAC5, 12);
        check("long_bit_cnt", bus.bit_cnt, 9);
        check("long_out_sr",  bus.out_sr,  8'hC5);
        check("long_so",      bus.so,      1);
        commit();
        check("long_load_err", bus.load_err, 1);
        check("long_out",      bus.out,      8'h69);
        check("long_sr_kept",  bus.out_sr,   8'hC5);
        check("long_bit_cnt0", bus.bit_cnt,  0);

        // Last bit shifted in the same cycle as ld still counts
        shift_word(12'h04B, 7);
        bus.si       = 1'b0;
        bus.shift_en = 1'b1;
        bus.ld       = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        bus.ld       = 1'b0;
        tick();
        check("same_out",      bus.out,      8'h96);
        check("same_loaded",   bus.loaded,   1);
        check("same_load_err", bus.load_err, 0);

        // shift_en and ld held high through LOAD are ignored
        shift_word(12'h0F0, 8);
        bus.ld = 1'b1;
        tick();
        bus.shift_en = 1'b1;
        bus.si       = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        bus.ld       = 1'b0;
        check("ign_out_sr",  bus.out_sr,  8'hF0);
        check("ign_bit_cnt", bus.bit_cnt, 0);
        check("ign_out",     bus.out,     8'hF0);
        tick();
        check("ign_no_recommit", bus.loaded, 0);

        // def_conf overrides the applied value without touching the latch
        bus.def_conf = 1'b1;
        bus.def_val  = 8'h3C;
        shift_word(12'h0FF, 8);
        commit();
        check("def_out",    bus.out,    8'h3C);
        check("def_loaded", bus.loaded, 1);
        bus.def_conf = 1'b0;
        #1;
        check("def_off_out", bus.out, 8'hFF);

        // Reset mid-frame discards it
        shift_word(12'h00B, 4);
        check("mid_bit_cnt", bus.bit_cnt, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_out_sr",   bus.out_sr,   8'h00);
        check("mid_rst_bit_cnt",  bus.bit_cnt,  0);
        check("mid_rst_out",      bus.out,      8'h00);
        check("mid_rst_load_err", bus.load_err, 0);
        bus.def_conf = 1'b1;
        bus.def_val  = 8'hC3;
        #1;
        check("mid_rst_out_def", bus.out, 8'hC3);
        bus.def_conf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        commit();
        check("empty_load_err", bus.load_err, 1);
        check("empty_loaded",   bus.loaded,   0);
        check("empty_out",      bus.out,      8'h00);

`ifdef CNFG_READBACK_EN
        // Readback of a committed value through so
        shift_word(12'h081, 8);
        commit();
        check("rb_commit_out", bus.out, 8'h81);
        bus.rb = 1'b1;
        tick();
        bus.rb = 1'b0;
        check("rb_out_sr",  bus.out_sr,  8'h81);
        check("rb_bit_cnt", bus.bit_cnt, 0);
        begin
            logic [7:0] exp_so;
            exp_so = 8'h81;
            for (int i = 7; i >= 0; i--) begin
                check($sformatf("rb_so_%0d", 7 - i), bus.so, exp_so[i]);
                shift_bit(1'b0);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
